// File: rtl/downsample_pkg.sv
// Shared encodings and width helpers for the 2x2 average-pool downsampler.
package downsample_pkg;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Position of a sample inside its 2x2 window, in read order
  localparam logic [1:0] PH_TL = 2'd0;
  localparam logic [1:0] PH_TR = 2'd1;
  localparam logic [1:0] PH_BL = 2'd2;
  localparam logic [1:0] PH_BR = 2'd3;

  // Input buffer address width for an img_w x img_w map
  function automatic int ds_addr_w(input int img_w);
    return 2 * $clog2(img_w);
  endfunction

  // Output buffer address width; a 2x2 map has a single output word but keeps a 1-bit port
  function automatic int ds_out_addr_w(input int img_w);
    return (img_w > 2) ? (2 * $clog2(img_w) - 2) : 1;
  endfunction

  // Input address of read k: window n = k/4 in raster order, sample order TL, TR, BL, BR
  function automatic int unsigned ds_rd_addr(input int unsigned k, input int unsigned img_w);
    int unsigned n, half, r, c;
    n    = k >> 2;
    half = img_w >> 1;
    r    = n / half;
    c    = n % half;
    return (2 * r + ((k >> 1) & 1)) * img_w + 2 * c + (k & 1);
  endfunction

endpackage

// File: rtl/avg_pool_acc.sv
// Accumulates the four samples of one 2x2 window and registers their floor-average.
module avg_pool_acc
  import downsample_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int OUT_ADDR_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic [1:0]                   phase,
  input  logic signed [DATA_W-1:0]     sample,
  input  logic [OUT_ADDR_W-1:0]        win_idx,
  output logic                         wr_en,
  output logic [OUT_ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0]     wr_data
);

  // Two guard bits hold the sum of four samples without overflow
  localparam int ACC_W = DATA_W + 2;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  assign sample_ext = {{2{sample[DATA_W-1]}}, sample};
  assign sum        = acc_q + sample_ext;

  // Accumulate per phase; the last sample of a window emits a one-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (valid) begin
        case (phase)
          PH_TL:        acc_q <= sample_ext;
          PH_TR, PH_BL: acc_q <= sum;
          PH_BR: begin
            wr_en   <= 1'b1;
            wr_addr <= win_idx;
            // Arithmetic shift gives floor division for negative sums too
            wr_data <= DATA_W'(sum >>> 2);
          end
          default: acc_q <= acc_q;
        endcase
      end
    end
  end

endmodule

// File: rtl/control_unit_downsample.sv
// Frame controller for 2x2 average-pool downsampling: sweeps the input buffer one
// read per cycle in window order and feeds the returning samples to the accumulator.
module control_unit_downsample
  import downsample_pkg::*;
#(
  parameter int  IMG_W      = 8,
  parameter int  DATA_W     = 16,
  localparam int ADDR_W     = ds_addr_w(IMG_W),
  localparam int OUT_ADDR_W = ds_out_addr_w(IMG_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     wr_en,
  output logic [OUT_ADDR_W-1:0]    wr_addr,
  output logic signed [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] K_LAST = {ADDR_W{1'b1}};

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     k_q, k_d;
  logic                  drain_q, drain_d;
  logic [ADDR_W-1:0]     addr_calc;
  logic [ADDR_W-1:0]     addr_hold_q;
  logic [OUT_ADDR_W-1:0] win_idx;

  // Read data returns one cycle later, so phase and window travel with it
  logic                  rd_valid_q;
  logic [1:0]            rd_phase_q;
  logic [OUT_ADDR_W-1:0] rd_win_q;

  assign addr_calc = ADDR_W'(ds_rd_addr(32'(k_q), $unsigned(IMG_W)));
  assign win_idx   = OUT_ADDR_W'(k_q >> 2);

  // Next-state logic: RUN for IMG_W^2 reads, two DRAIN cycles, one DONE cycle
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // k wraps to zero on the final read, ready for the next frame
        k_d = k_q + ADDR_W'(1);
        if (k_q == K_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state, read counter and the read pipeline tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      drain_q     <= 1'b0;
      addr_hold_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_phase_q  <= PH_TL;
      rd_win_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      rd_valid_q <= (state_q == ST_RUN);
      rd_phase_q <= k_q[1:0];
      rd_win_q   <= win_idx;
      if (state_q == ST_RUN) addr_hold_q <= addr_calc;
    end
  end

  // Status and read-port outputs; rd_addr keeps the last issued address outside RUN
  always_comb begin
    busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done    = (state_q == ST_DONE);
    rd_en   = (state_q == ST_RUN);
    rd_addr = rd_en ? addr_calc : addr_hold_q;
  end

  avg_pool_acc #(
    .DATA_W     (DATA_W),
    .OUT_ADDR_W (OUT_ADDR_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .valid   (rd_valid_q),
    .phase   (rd_phase_q),
    .sample  (rd_data),
    .win_idx (rd_win_q),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_control_unit_downsample.sv
// Scoreboard bench for control_unit_downsample: an 8x8 instance driven from a buffer
// model, plus 2x2 and 16x16 instances fed a constant sample.
module tb_control_unit_downsample;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_s;

  always #5 clk = ~clk;

  // Main 8x8 instance
  logic               busy, done, rd_en, wr_en;
  logic [5:0]         rd_addr;
  logic [3:0]         wr_addr;
  logic signed [15:0] rd_data, wr_data;

  // 2x2 instance
  logic               busy2, done2, rd_en2, wr_en2;
  logic [1:0]         rd_addr2;
  logic [0:0]         wr_addr2;
  logic signed [15:0] rd_data2, wr_data2;

  // 16x16 instance
  logic               busy16, done16, rd_en16, wr_en16;
  logic [7:0]         rd_addr16;
  logic [5:0]         wr_addr16;
  logic signed [15:0] rd_data16, wr_data16;

  assign rd_data2  = -16'sd3;
  assign rd_data16 = 16'sd7;

  control_unit_downsample #(.IMG_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  control_unit_downsample #(.IMG_W(2), .DATA_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
  );

  control_unit_downsample #(.IMG_W(16), .DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy16), .done(done16),
    .rd_en(rd_en16), .rd_addr(rd_addr16), .rd_data(rd_data16),
    .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16)
  );

  // Synchronous input buffer: data appears the cycle after the read
  logic signed [15:0] mem [64];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                 cyc_at;
    logic [3:0]         addr;
    logic signed [15:0] data;
  } wr_item_t;

  wr_item_t wr_q[$];
  int       done_q[$];
  wr_item_t mon_it;
  int       mon_d;

  // Monitor: every write and done pulse of the main instance is matched against the queues
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d required no write",
                 cyc, wr_addr, wr_data);
      end else begin
        mon_it = wr_q.pop_front();
        if (wr_addr !== mon_it.addr || wr_data !== mon_it.data || cyc != mon_it.cyc_at) begin
          errors++;
          $display("FAIL write got addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d cyc=%0d",
                   wr_addr, wr_data, cyc, mon_it.addr, mon_it.data, mon_it.cyc_at);
        end
      end
    end
    if (done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d required no done", cyc);
      end else begin
        mon_d = done_q.pop_front();
        if (cyc != mon_d) begin
          errors++;
          $display("FAIL done_cycle got cyc=%0d required cyc=%0d", cyc, mon_d);
        end
      end
    end
  end

  // Side instances: constant map, writes at 4n+5 in address order
  int ts = 0;
  int cnt2 = 0, cnt16 = 0, dn2 = 0, dn16 = 0;

  always @(negedge clk) begin
    if (wr_en2) begin
      checks++;
      if (wr_addr2 !== 1'(cnt2) || wr_data2 !== -16'sd3 || cyc != ts + 4 * cnt2 + 5) begin
        errors++;
        $display("FAIL w2_write got addr=%0d data=%0d cyc=%0d required addr=%0d data=-3 cyc=%0d",
                 wr_addr2, wr_data2, cyc, cnt2, ts + 4 * cnt2 + 5);
      end
      cnt2++;
    end
    if (done2) begin
      checks++;
      dn2++;
      if (cyc != ts + 6) begin
        errors++;
        $display("FAIL w2_done got cyc=%0d required cyc=%0d", cyc, ts + 6);
      end
    end
    if (wr_en16) begin
      checks++;
      if (wr_addr16 !== 6'(cnt16) || wr_data16 !== 16'sd7 || cyc != ts + 4 * cnt16 + 5) begin
        errors++;
        $display("FAIL w16_write got addr=%0d data=%0d cyc=%0d required addr=%0d data=7 cyc=%0d",
                 wr_addr16, wr_data16, cyc, cnt16, ts + 4 * cnt16 + 5);
      end
      cnt16++;
    end
    if (done16) begin
      checks++;
      dn16++;
      if (cyc != ts + 258) begin
        errors++;
        $display("FAIL w16_done got cyc=%0d required cyc=%0d", cyc, ts + 258);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (wr_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d writes and %0d done pending required 0 and 0",
               name, wr_q.size(), done_q.size());
    end
  endtask

  // kind 0: constant 100; kind 1: ramp (sample = address); kind 2: signed floor case
  task automatic fill(input int kind);
    for (int a = 0; a < 64; a++) begin
      case (kind)
        0:       mem[a] = 16'sd100;
        1:       mem[a] = 16'(a);
        default: mem[a] = 16'sh7FFF;
      endcase
    end
    if (kind == 2) begin
      mem[0] = -16'sd1;
      mem[1] = -16'sd2;
      mem[8] = -16'sd2;
      mem[9] = -16'sd2;
    end
  endtask

  // Expected writes: window n = 4r+c covers addresses 16r+2c, +1, +8, +9
  task automatic push_frame(input int t0, input int kind);
    wr_item_t it;
    for (int n = 0; n < 16; n++) begin
      it.cyc_at = t0 + 4 * n + 5;
      it.addr   = 4'(n);
      case (kind)
        0:       it.data = 16'sd100;
        1:       it.data = 16'(16 * (n / 4) + 2 * (n % 4) + 4);
        default: it.data = (n == 0) ? -16'sd2 : 16'sh7FFF;
      endcase
      wr_q.push_back(it);
    end
    done_q.push_back(t0 + 66);
  endtask

  // Pulse start for one edge; t0 is the cycle counter value during RUN cycle 0
  task automatic launch(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_rd_en"}, rd_en, 0);
    check({pfx, "_rd_addr"}, rd_addr, 0);
    check({pfx, "_wr_en"}, wr_en, 0);
    check({pfx, "_wr_addr"}, wr_addr, 0);
    check({pfx, "_wr_data"}, wr_data, 0);
  endtask

  int t0;
  int seq [8];

  initial begin
    seq = '{0, 1, 8, 9, 2, 3, 10, 11};
    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Constant map
    fill(0);
    launch(t0);
    push_frame(t0, 0);
    check("run_busy", busy, 1);
    check("run_rd_en", rd_en, 1);
    repeat (72) @(negedge clk);
    check_drained("const_frame");

    // Ramp map with read-order and DRAIN checks
    fill(1);
    launch(t0);
    push_frame(t0, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rd_addr_seq%0d", i), rd_addr, seq[i]);
      @(posedge clk);
      #1;
    end
    repeat (56) @(posedge clk);
    #1;
    check("drain_rd_en", rd_en, 0);
    check("drain_rd_addr_hold", rd_addr, 63);
    check("drain_busy", busy, 1);
    repeat (10) @(negedge clk);
    check_drained("ramp_frame");

    // Signed floor and full-scale samples
    fill(2);
    launch(t0);
    push_frame(t0, 2);
    repeat (72) @(negedge clk);
    check_drained("signed_frame");

    // Asynchronous reset in cycle 30
    fill(0);
    launch(t0);
    push_frame(t0, 0);
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    wr_q.delete();
    done_q.delete();
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("no_restart_busy", busy, 0);
    check_drained("after_reset");

    fill(1);
    launch(t0);
    push_frame(t0, 1);
    repeat (72) @(negedge clk);
    check_drained("recovery_frame");

    // start toggled during RUN, then held through DONE for an immediate relaunch
    fill(0);
    launch(t0);
    push_frame(t0, 0);
    push_frame(t0 + 68, 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = (i % 3 == 0);
    end
    start = 1'b1;
    repeat (9) @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    check_drained("start_busy_frames");

    // Parameter sweep: 2x2 and 16x16 together
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    ts = cyc;
    start_s = 1'b0;
    repeat (270) @(negedge clk);
    check("w2_write_count", cnt2, 1);
    check("w2_done_count", dn2, 1);
    check("w16_write_count", cnt16, 64);
    check("w16_done_count", dn16, 1);
    check_drained("sweep_main_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
